// File: rtl/asset_load_sequencer.sv
// asset_load_sequencer: clears downstream, loads N_PIXELS words into image memory, then assembles HPS render commands.
// Optional LOAD_CHECKSUM_EN adds a load_sum output with the byte sum of every loaded pixel word.
module asset_load_sequencer #(
    parameter int          PIXEL_BYTES = 3,
    parameter int          N_PIXELS    = 512,
    parameter int          ADDR_W      = 9,
    parameter int          CMD_BYTES   = 6,
    parameter logic [7:0]  RESET_CMD   = 8'hFE
) (
    input  logic                     clk50,
    input  logic                     reset_n,
    input  logic [8*PIXEL_BYTES-1:0] src_data,
    input  logic                     src_valid,
    output logic                     src_pop,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [8*PIXEL_BYTES-1:0] mem_din,
    input  logic                     hps_write,
    input  logic                     hps_chipselect,
    input  logic [2:0]               hps_address,
    input  logic [7:0]               hps_writedata,
    output logic [8*CMD_BYTES-1:0]   cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     do_clear,
    output logic                     load_done,
`ifdef LOAD_CHECKSUM_EN
    output logic [15:0]              load_sum,
`endif
    output logic                     cmd_overflow
);
    localparam int               CW   = 8*CMD_BYTES;
    localparam logic [ADDR_W:0]  NP   = N_PIXELS[ADDR_W:0];
    localparam logic [2:0]       LAST = 3'(CMD_BYTES-1);
    localparam logic [3:0]       NB   = 4'(CMD_BYTES);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t          r_state;
    logic [ADDR_W:0] r_count;
    logic [CW-1:0]   r_stage;
    logic [CW-1:0]   w_stage_next;
    logic            w_wr;
    logic            w_in_range;
    logic            w_rst_cmd;
    logic            w_commit;
    logic            w_last;

    assign src_pop    = (r_state == LOAD) && src_valid && (r_count < NP);
    assign w_last     = r_count == NP - 1'b1;
    assign w_wr       = (r_state == RUN) && hps_write && hps_chipselect;
    assign w_in_range = {1'b0, hps_address} < NB;
    assign w_rst_cmd  = w_wr && hps_address == 3'd0 && hps_writedata == RESET_CMD;
    assign w_commit   = w_wr && hps_address == LAST && !w_rst_cmd;

    // Byte 0 lands in the most significant byte of the command word
    always_comb begin
        w_stage_next = r_stage;
        for (int i = 0; i < CMD_BYTES; i++)
            if (hps_address == 3'(i)) w_stage_next[CW-8-8*i +: 8] = hps_writedata;
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] w_pix_sum;
    always_comb begin
        w_pix_sum = '0;
        for (int i = 0; i < PIXEL_BYTES; i++) w_pix_sum = w_pix_sum + 16'(src_data[8*i +: 8]);
    end
`endif

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= CLEAR;
            r_count      <= '0;
            r_stage      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            cmd_data     <= '0;
            cmd_valid    <= 1'b0;
            do_clear     <= 1'b0;
            load_done    <= 1'b0;
            cmd_overflow <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            load_sum     <= '0;
`endif
        end else begin
            case (r_state)
                CLEAR: begin
                    // A reset command already raised do_clear; after reset_n it is raised here, once either way
                    do_clear     <= !do_clear;
                    r_count      <= '0;
                    mem_we       <= 1'b0;
                    cmd_valid    <= 1'b0;
                    cmd_overflow <= 1'b0;
                    load_done    <= 1'b0;
                    r_state      <= LOAD;
`ifdef LOAD_CHECKSUM_EN
                    load_sum     <= '0;
`endif
                end
                LOAD: begin
                    do_clear <= 1'b0;
                    mem_we   <= src_pop;
                    if (src_pop) begin
                        mem_addr <= r_count[ADDR_W-1:0];
                        mem_din  <= src_data;
                        r_count  <= r_count + 1'b1;
`ifdef LOAD_CHECKSUM_EN
                        load_sum <= load_sum + w_pix_sum;
`endif
                        if (w_last) begin
                            r_state   <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    mem_we <= 1'b0;
                    if (w_rst_cmd) begin
                        r_state   <= CLEAR;
                        do_clear  <= 1'b1;
                        load_done <= 1'b0;
                        cmd_valid <= 1'b0;
                    end else begin
                        if (w_wr && w_in_range) r_stage <= w_stage_next;
                        if (w_commit && (!cmd_valid || cmd_ready)) begin
                            cmd_data  <= w_stage_next;
                            cmd_valid <= 1'b1;
                        end else begin
                            if (w_commit) cmd_overflow <= 1'b1;
                            if (cmd_ready) cmd_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_asset_load_sequencer.sv
// tb_asset_load_sequencer: directed checks of load, command assembly/handshake, reset command and async reset.
module tb_asset_load_sequencer;
    logic        clk50;
    logic        reset_n;
    logic [23:0] src_data;
    logic        src_valid;
    logic        src_pop;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [23:0] mem_din;
    logic        hps_write;
    logic        hps_chipselect;
    logic [2:0]  hps_address;
    logic [7:0]  hps_writedata;
    logic [47:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        do_clear;
    logic        load_done;
    logic        cmd_overflow;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0] load_sum;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int pops;
    logic [23:0] pix [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  cmd_a [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    asset_load_sequencer #(
        .PIXEL_BYTES(3), .N_PIXELS(4), .ADDR_W(2), .CMD_BYTES(6), .RESET_CMD(8'hFE)
    ) dut (
        .clk50(clk50), .reset_n(reset_n),
        .src_data(src_data), .src_valid(src_valid), .src_pop(src_pop),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .hps_write(hps_write), .hps_chipselect(hps_chipselect),
        .hps_address(hps_address), .hps_writedata(hps_writedata),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .do_clear(do_clear), .load_done(load_done),
`ifdef LOAD_CHECKSUM_EN
        .load_sum(load_sum),
`endif
        .cmd_overflow(cmd_overflow)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk50);
        #1;
    endtask

    task automatic hps_wr(input logic [2:0] a, input logic [7:0] d);
        hps_write = 1'b1; hps_chipselect = 1'b1; hps_address = a; hps_writedata = d;
        tick();
        hps_write = 1'b0; hps_chipselect = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pop"},  64'(src_pop), 64'd0);
        chk({tag, "_we"},   64'(mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_din"},  64'(mem_din), 64'd0);
        chk({tag, "_cmd"},  64'(cmd_data), 64'd0);
        chk({tag, "_cv"},   64'(cmd_valid), 64'd0);
        chk({tag, "_clr"},  64'(do_clear), 64'd0);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
        chk({tag, "_ovf"},  64'(cmd_overflow), 64'd0);
`ifdef LOAD_CHECKSUM_EN
        chk({tag, "_sum"},  64'(load_sum), 64'd0);
`endif
    endtask

    task automatic full_load(input string tag);
        tick();
        chk({tag, "_clr_pulse"}, 64'(do_clear), 64'd1);
        chk({tag, "_pop_first"}, 64'(src_pop), 64'd1);
        for (int i = 0; i < 4; i++) begin
            src_data = pix[i];
            tick();
            chk({tag, "_we"},   64'(mem_we), 64'd1);
            chk({tag, "_addr"}, 64'(mem_addr), 64'(i));
            chk({tag, "_din"},  64'(mem_din), 64'(pix[i]));
            chk({tag, "_clr"},  64'(do_clear), 64'd0);
            chk({tag, "_done"}, 64'(load_done), 64'(i == 3));
        end
        chk({tag, "_pop_end"}, 64'(src_pop), 64'd0);
        tick();
        chk({tag, "_we_off"}, 64'(mem_we), 64'd0);
        chk({tag, "_done_hold"}, 64'(load_done), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0; src_valid = 1'b1; src_data = pix[0];
        hps_write = 1'b0; hps_chipselect = 1'b0; hps_address = 3'd0; hps_writedata = 8'd0;
        cmd_ready = 1'b0;
        #1;
        check_zero("rst");
        tick(); tick();
        reset_n = 1'b1;
        chk("clear_no_pop", 64'(src_pop), 64'd0);

        // Initial load with a continuously valid staging FIFO
        full_load("load1");
`ifdef LOAD_CHECKSUM_EN
        chk("sum1", 64'(load_sum), 64'h4E);
`endif

        // Six-byte command, queue stalled for three cycles
        for (int k = 0; k < 6; k++) hps_wr(3'(k), cmd_a[k]);
        chk("cmd1_valid", 64'(cmd_valid), 64'd1);
        chk("cmd1_data", 64'(cmd_data), 64'h112233445566);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cmd1_hold_v", 64'(cmd_valid), 64'd1);
            chk("cmd1_hold_d", 64'(cmd_data), 64'h112233445566);
        end
        cmd_ready = 1'b1;
        tick();
        chk("cmd1_taken", 64'(cmd_valid), 64'd0);
        chk("cmd1_ovf", 64'(cmd_overflow), 64'd0);
        cmd_ready = 1'b0;

        // Second commit while the first is still waiting is dropped
        for (int k = 0; k < 6; k++) hps_wr(3'(k), 8'hA1 + 8'(k));
        chk("cmd2_data", 64'(cmd_data), 64'hA1A2A3A4A5A6);
        for (int k = 0; k < 6; k++) hps_wr(3'(k), 8'hB1 + 8'(k));
        chk("ovf_set", 64'(cmd_overflow), 64'd1);
        chk("ovf_data", 64'(cmd_data), 64'hA1A2A3A4A5A6);
        chk("ovf_valid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        tick();
        chk("ovf_taken", 64'(cmd_valid), 64'd0);
        tick();
        chk("ovf_no_extra", 64'(cmd_valid), 64'd0);
        chk("ovf_sticky", 64'(cmd_overflow), 64'd1);
        cmd_ready = 1'b0;

        // Commit a pending command, then a reset command discards it and reloads with gaps
        hps_wr(3'd6, 8'hEE);
        hps_wr(3'd5, 8'hD6);
        chk("cmd3_data", 64'(cmd_data), 64'hB1B2B3B4B5D6);
        chk("cmd3_valid", 64'(cmd_valid), 64'd1);
        src_valid = 1'b0;
        hps_wr(3'd0, 8'hFE);
        chk("rc_clear", 64'(do_clear), 64'd1);
        chk("rc_done", 64'(load_done), 64'd0);
        chk("rc_cv", 64'(cmd_valid), 64'd0);
        tick();
        chk("rc_clr_once", 64'(do_clear), 64'd0);
        chk("rc_ovf_clr", 64'(cmd_overflow), 64'd0);
        pops = 0;
        for (int j = 0; j < 7; j++) begin
            src_valid = pat[j];
            src_data = pix[pops];
            #1;
            chk("gap_pop", 64'(src_pop), 64'(pat[j]));
            tick();
            chk("gap_we", 64'(mem_we), 64'(pat[j]));
            if (pat[j]) begin
                chk("gap_addr", 64'(mem_addr), 64'(pops));
                chk("gap_din", 64'(mem_din), 64'(pix[pops]));
                pops++;
            end
        end
        chk("gap_done", 64'(load_done), 64'd1);
        src_valid = 1'b0;
        tick();
        chk("gap_we_off", 64'(mem_we), 64'd0);
        chk("gap_cmd_kept", 64'(cmd_data), 64'hB1B2B3B4B5D6);

        // Async reset after two of four pixels
        hps_wr(3'd0, 8'hFE);
        tick();
        src_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            src_data = pix[i];
            tick();
            chk("part_addr", 64'(mem_addr), 64'(i));
        end
        #3 reset_n = 1'b0;
        #1;
        check_zero("arst");
        tick();
        reset_n = 1'b1;
        src_data = pix[0];
        full_load("load2");
`ifdef LOAD_CHECKSUM_EN
        chk("sum2", 64'(load_sum), 64'h4E);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
